fmmot_capture_ctrl: RTL

Capture and readout sequencer for the FM-MOT difference memory. Gates per-cycle sample strobes from the FM-MOT module into a pair of `ram_dual` buffers, with arm/trigger/stop control and one-shot or continuous (ring) capture. After capture it hands the frozen record to a slow requester (host/ILA bridge) one sample pair per request, oldest first.

---
 rtl/fmmot_capture_ctrl_pkg.sv | 21 ++
 rtl/fmmot_rd_pipe.sv | 50 +++++
 rtl/fmmot_capture_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fmmot_capture_ctrl_pkg.sv
// Shared types and sizing helpers for the FM-MOT capture/readout sequencer.
package fmmot_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_MEMSIZE = 1024;
  localparam int unsigned DEF_SIGSIZE = 16;

  // Buffer address width for a power-of-two depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned DEF_ADDRWIDTH = addr_width(DEF_MEMSIZE);

endpackage

// File: rtl/fmmot_rd_pipe.sv
// Three-stage read pipeline: request -> RAM address -> RAM data -> dout/rd_valid.
module fmmot_rd_pipe #(
  parameter int unsigned SIGSIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               last,
  input  logic [SIGSIZE-1:0] rd0,
  input  logic [SIGSIZE-1:0] rd1,
  output logic               busy,
  output logic               rd_valid,
  output logic               rd_last,
  output logic [SIGSIZE-1:0] dout0,
  output logic [SIGSIZE-1:0] dout1
);

  logic p1_q;
  logic p2_q;
  logic l1_q;
  logic l2_q;

  // busy covers the address and data stages; it drops as rd_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      l1_q     <= 1'b0;
      l2_q     <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      dout0    <= '0;
      dout1    <= '0;
    end else begin
      p1_q     <= req;
      p2_q     <= p1_q;
      l1_q     <= last;
      l2_q     <= l1_q;
      busy     <= req || p1_q;
      rd_valid <= p2_q;
      rd_last  <= p2_q && l2_q;
      if (p2_q) begin
        dout0 <= rd0;
        dout1 <= rd1;
      end
    end
  end

endmodule

// File: rtl/fmmot_capture_ctrl.sv
// Capture/readout sequencer: gates FM-MOT strobes into the dual buffers and
// replays the frozen record oldest-first, one pair per request.
module fmmot_capture_ctrl
  import fmmot_capture_ctrl_pkg::*;
#(
  parameter int unsigned MEMSIZE   = DEF_MEMSIZE,
  parameter int unsigned SIGSIZE   = DEF_SIGSIZE,
  parameter int unsigned ADDRWIDTH = addr_width(MEMSIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 cont,
  input  logic                 trig,
  input  logic                 stop,
  input  logic                 stb,
  input  logic [SIGSIZE-1:0]   in0,
  input  logic [SIGSIZE-1:0]   in1,
  output logic                 we,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [SIGSIZE-1:0]   wd0,
  output logic [SIGSIZE-1:0]   wd1,
  output logic [ADDRWIDTH-1:0] raddr,
  input  logic [SIGSIZE-1:0]   rd0,
  input  logic [SIGSIZE-1:0]   rd1,
  input  logic                 rd_req,
  output logic                 rd_valid,
  output logic [SIGSIZE-1:0]   dout0,
  output logic [SIGSIZE-1:0]   dout1,
  output logic                 rd_last,
  output logic                 busy,
  output logic [1:0]           state,
  output logic [ADDRWIDTH:0]   count
);

  localparam int unsigned CW = ADDRWIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(MEMSIZE);
  localparam logic [ADDRWIDTH-1:0] ADDR_MAX = ADDRWIDTH'(MEMSIZE - 1);

  state_t               st_q;
  logic                 cont_q;
  logic                 wrapped_q;
  logic [ADDRWIDTH-1:0] rdptr_q;

  logic                 capture_c;
  logic                 accept_c;
  logic                 last_c;
  logic                 wrap_nxt_c;
  logic [ADDRWIDTH-1:0] waddr_nxt_c;
  logic [ADDRWIDTH-1:0] oldest_c;

  // waddr holds the write address while we is high and steps at the commit edge,
  // so after capture it already points at the oldest slot of a wrapped ring.
  always_comb begin
    capture_c   = stb && ((st_q == ST_CAPTURE) || ((st_q == ST_ARMED) && trig));
    waddr_nxt_c = we ? waddr + ADDRWIDTH'(1) : waddr;
    wrap_nxt_c  = wrapped_q || (we && cont_q && (waddr == ADDR_MAX));
    oldest_c    = wrap_nxt_c ? waddr_nxt_c : '0;
    accept_c    = (st_q == ST_DONE) && rd_req && !busy && (count != '0);
    last_c      = (CW'(rdptr_q) == (count - CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cont_q    <= 1'b0;
      wrapped_q <= 1'b0;
      rdptr_q   <= '0;
      count     <= '0;
      waddr     <= '0;
      we        <= 1'b0;
      wd0       <= '0;
      wd1       <= '0;
      raddr     <= '0;
    end else begin
      we        <= capture_c;
      waddr     <= waddr_nxt_c;
      wrapped_q <= wrap_nxt_c;
      if (capture_c) begin
        wd0 <= in0;
        wd1 <= in1;
        if (count != FULL) begin
          count <= count + CW'(1);
        end
      end
      if (accept_c) begin
        raddr   <= oldest_c + rdptr_q;
        rdptr_q <= last_c ? '0 : rdptr_q + ADDRWIDTH'(1);
      end
      case (st_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            st_q      <= ST_ARMED;
            cont_q    <= cont;
            count     <= '0;
            waddr     <= '0;
            wrapped_q <= 1'b0;
            rdptr_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            st_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // The filling strobe of a one-shot is still written on the way to DONE.
          if (capture_c && !cont_q && (count == (FULL - CW'(1)))) begin
            st_q <= ST_DONE;
          end else if (cont_q && stop) begin
            st_q <= ST_DONE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign state = st_q;

  fmmot_rd_pipe #(
    .SIGSIZE(SIGSIZE)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .req      (accept_c),
    .last     (last_c),
    .rd0      (rd0),
    .rd1      (rd1),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .dout0    (dout0),
    .dout1    (dout1)
  );

endmodule
